butterfly_dif: RTL and testbench

Pipelined radix-2 decimation-in-frequency butterfly, the inverse-direction counterpart of the existing DIT butterfly used in the 256-point FFT datapath.
- Computes X0 = a + b and X1 = (a - b) * W.
- Optionally conjugates W, so the same block serves the IFFT.
- Uses a valid/ready handshake with a global stall so it can sit between stage buffers that apply backpressure.

---
 rtl/butterfly_dif.sv | 137 +++++++++++++
 tb/tb_butterfly_dif.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/butterfly_dif.sv
// Pipelined radix-2 DIF butterfly: X0 = a + b, X1 = (a - b) * W (or conj(W)).
// Three register stages sharing one advance enable so a downstream stall freezes the whole pipe.
module butterfly_dif #(
   parameter int totalbits = 30,
   parameter int TW_FRAC   = 14,
   parameter int TAGW      = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [totalbits-1:0] realin0,
   input  logic signed [totalbits-1:0] imagin0,
   input  logic signed [totalbits-1:0] realin1,
   input  logic signed [totalbits-1:0] imagin1,
   input  logic signed [totalbits-1:0] twiddle_real,
   input  logic signed [totalbits-1:0] twiddle_imag,
   input  logic                        inverse,
   input  logic                        scale_en,
   input  logic [TAGW-1:0]             tag_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [totalbits-1:0] realout0,
   output logic signed [totalbits-1:0] imagout0,
   output logic signed [totalbits-1:0] realout1,
   output logic signed [totalbits-1:0] imagout1,
   output logic [TAGW-1:0]             tag_out
);
   localparam int W  = totalbits;
   localparam int PW = 2 * totalbits;
   localparam logic [PW:0] C_RND = (PW + 1)'(1) << (TW_FRAC - 1);

   // Valid/ready: a pair moves across an interface on a clock edge where valid and
   // ready are both high; the whole pipe advances whenever the output slot is free
   // or is being consumed, and holds every register otherwise.
   logic w_adv;

   logic                r_v1, r_v2, r_v3;
   logic [TAGW-1:0]     r_tag1, r_tag2, r_tag3;
   logic signed [W-1:0] r_sr1, r_si1, r_dr1, r_di1, r_wr1, r_wi1;
   logic signed [W-1:0] r_sr2, r_si2;
   logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic signed [W-1:0] r_o0r, r_o0i, r_o1r, r_o1i;

   assign w_adv    = out_ready | ~r_v3;
   assign in_ready = w_adv;

   // Stage 1 arithmetic is done one bit wider so the optional halving sees the true sum.
   logic signed [W:0]   w_sr_full, w_si_full, w_dr_full, w_di_full;
   logic signed [W-1:0] w_sr, w_si, w_dr, w_di, w_wi;

   assign w_sr_full = {realin0[W-1], realin0} + {realin1[W-1], realin1};
   assign w_si_full = {imagin0[W-1], imagin0} + {imagin1[W-1], imagin1};
   assign w_dr_full = {realin0[W-1], realin0} - {realin1[W-1], realin1};
   assign w_di_full = {imagin0[W-1], imagin0} - {imagin1[W-1], imagin1};

   assign w_sr = scale_en ? w_sr_full[W:1] : w_sr_full[W-1:0];
   assign w_si = scale_en ? w_si_full[W:1] : w_si_full[W-1:0];
   assign w_dr = scale_en ? w_dr_full[W:1] : w_dr_full[W-1:0];
   assign w_di = scale_en ? w_di_full[W:1] : w_di_full[W-1:0];
   assign w_wi = inverse ? -twiddle_imag : twiddle_imag;

   // Operands sign-extended to product width so the multiplies are full precision.
   logic signed [PW-1:0] w_dr_x, w_di_x, w_wr_x, w_wi_x;
   assign w_dr_x = {{W{r_dr1[W-1]}}, r_dr1};
   assign w_di_x = {{W{r_di1[W-1]}}, r_di1};
   assign w_wr_x = {{W{r_wr1[W-1]}}, r_wr1};
   assign w_wi_x = {{W{r_wi1[W-1]}}, r_wi1};

   logic signed [PW:0] w_pr, w_pi, w_pr_rnd, w_pi_rnd, w_pr_sh, w_pi_sh;
   assign w_pr     = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
   assign w_pi     = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};
   assign w_pr_rnd = w_pr + C_RND;
   assign w_pi_rnd = w_pi + C_RND;
   assign w_pr_sh  = w_pr_rnd >>> TW_FRAC;
   assign w_pi_sh  = w_pi_rnd >>> TW_FRAC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_tag1 <= '0;
         r_tag2 <= '0;
         r_tag3 <= '0;
         r_sr1  <= '0;
         r_si1  <= '0;
         r_dr1  <= '0;
         r_di1  <= '0;
         r_wr1  <= '0;
         r_wi1  <= '0;
         r_sr2  <= '0;
         r_si2  <= '0;
         r_p_rr <= '0;
         r_p_ii <= '0;
         r_p_ri <= '0;
         r_p_ir <= '0;
         r_o0r  <= '0;
         r_o0i  <= '0;
         r_o1r  <= '0;
         r_o1i  <= '0;
      end else if (w_adv) begin
         r_v1   <= in_valid;
         r_tag1 <= tag_in;
         r_sr1  <= w_sr;
         r_si1  <= w_si;
         r_dr1  <= w_dr;
         r_di1  <= w_di;
         r_wr1  <= twiddle_real;
         r_wi1  <= w_wi;

         r_v2   <= r_v1;
         r_tag2 <= r_tag1;
         r_sr2  <= r_sr1;
         r_si2  <= r_si1;
         r_p_rr <= w_dr_x * w_wr_x;
         r_p_ii <= w_di_x * w_wi_x;
         r_p_ri <= w_dr_x * w_wi_x;
         r_p_ir <= w_di_x * w_wr_x;

         r_v3   <= r_v2;
         r_tag3 <= r_tag2;
         r_o0r  <= r_sr2;
         r_o0i  <= r_si2;
         r_o1r  <= w_pr_sh[W-1:0];
         r_o1i  <= w_pi_sh[W-1:0];
      end
   end

   assign out_valid = r_v3;
   assign tag_out   = r_tag3;
   assign realout0  = r_o0r;
   assign imagout0  = r_o0i;
   assign realout1  = r_o1r;
   assign imagout1  = r_o1i;

endmodule

// File: tb/tb_butterfly_dif.sv
// Directed bench for butterfly_dif: vector table, backpressure stream and mid-flight reset.
module tb_butterfly_dif;
   localparam int W    = 30;
   localparam int TAGW = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] realin0 = '0, imagin0 = '0, realin1 = '0, imagin1 = '0;
   logic signed [W-1:0] twiddle_real = '0, twiddle_imag = '0;
   logic                inverse = 1'b0, scale_en = 1'b0;
   logic [TAGW-1:0]     tag_in = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic signed [W-1:0] realout0, imagout0, realout1, imagout1;
   logic [TAGW-1:0]     tag_out;

   int n_checks = 0;
   int n_errors = 0;

   butterfly_dif #(.totalbits(W), .TW_FRAC(14), .TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .realin0(realin0), .imagin0(imagin0), .realin1(realin1), .imagin1(imagin1),
      .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
      .inverse(inverse), .scale_en(scale_en), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .realout0(realout0), .imagout0(imagout0), .realout1(realout1), .imagout1(imagout1),
      .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ar, ai, br, bi, wr, wi;
      bit inv, sc;
      int tag;
      int e0r, e0i, e1r, e1i;
   } vec_t;

   vec_t vecs[8];
   logic [TAGW-1:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      realin0      = v.ar[W-1:0];
      imagin0      = v.ai[W-1:0];
      realin1      = v.br[W-1:0];
      imagin1      = v.bi[W-1:0];
      twiddle_real = v.wr[W-1:0];
      twiddle_imag = v.wi[W-1:0];
      inverse      = v.inv;
      scale_en     = v.sc;
      tag_in       = v.tag[TAGW-1:0];
   endtask

   // One pair in, wait for it with out_ready held high, check values, latency and pulse width.
   task automatic apply_vec(input vec_t v, input string nm);
      int lat;
      out_ready = 1'b1;
      @(posedge clk); #1;
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, lat, 3);
      chk({nm, " out_valid"}, int'(out_valid), 1);
      chk({nm, " realout0"}, int'(realout0), v.e0r);
      chk({nm, " imagout0"}, int'(imagout0), v.e0i);
      chk({nm, " realout1"}, int'(realout1), v.e1r);
      chk({nm, " imagout1"}, int'(imagout1), v.e1i);
      chk({nm, " tag_out"}, int'(tag_out), v.tag);
      @(posedge clk); #1;
      chk({nm, " out_valid pulse"}, int'(out_valid), 0);
   endtask

   initial begin
      int sent, rcvd, stall, cyc, t;
      vec_t v;

      //           ar         ai   br  bi  wr     wi      inv sc tag    e0r         e0i  e1r         e1i
      vecs[0] = '{100,       50,  20, 10, 16384, 0,      0,  0, 8'hA1, 120,        60,  80,         40};
      vecs[1] = '{100,       50,  20, 10, 0,     -16384, 0,  0, 8'hA2, 120,        60,  40,         -80};
      vecs[2] = '{100,       50,  20, 10, 0,     -16384, 1,  0, 8'hA3, 120,        60,  -40,        80};
      vecs[3] = '{3,         0,   0,  0,  8192,  0,      0,  0, 8'hA4, 3,          0,   2,          0};
      vecs[4] = '{5,         -5,  0,  0,  16384, 0,      0,  1, 8'hA5, 2,          -3,  2,          -3};
      vecs[5] = '{536870911, 0,   1,  0,  16384, 0,      0,  0, 8'hA6, -536870912, 0,   536870910,  0};
      vecs[6] = '{536870911, 0,   1,  0,  16384, 0,      0,  1, 8'hA7, 268435456,  0,   268435455,  0};
      vecs[7] = '{-7,        3,   2,  -4, 11585, 11585,  0,  0, 8'hA8, -5,         -1,  -11,        -1};

      #12;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset realout0", int'(realout0), 0);
      chk("reset realout1", int'(realout1), 0);
      chk("reset tag_out", int'(tag_out), 0);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready", int'(in_ready), 1);

      for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: tags 1..6, a=(10t,t), b=(t,0), W=1 -> X0=(11t,t), X1=(9t,t).
      sent = 0; rcvd = 0; stall = -1; cyc = 0;
      while (rcvd < 6 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (sent < 6) begin
            t = sent + 1;
            v = '{10*t, t, t, 0, 16384, 0, 0, 0, t, 0, 0, 0, 0};
            drive(v);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("bp unexpected output", int'(tag_out), -1);
            end else begin
               t = int'(exp_q[0]);
               chk("bp tag", int'(tag_out), t);
               chk("bp realout0", int'(realout0), 11*t);
               chk("bp imagout0", int'(imagout0), t);
               chk("bp realout1", int'(realout1), 9*t);
               chk("bp imagout1", int'(imagout1), t);
               if (!out_ready) chk("bp in_ready in stall", int'(in_ready), 0);
               else begin
                  void'(exp_q.pop_front());
                  rcvd++;
                  if (stall < 0) stall = 4;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(TAGW'(sent + 1));
            sent++;
         end
      end
      chk("bp received count", rcvd, 6);
      chk("bp stall applied", stall, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;

      // Reset with two pairs in flight.
      drive(vecs[0]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(vecs[1]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst realout0", int'(realout0), 0);
      chk("rst imagout0", int'(imagout0), 0);
      chk("rst realout1", int'(realout1), 0);
      chk("rst imagout1", int'(imagout1), 0);
      chk("rst tag_out", int'(tag_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      t = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) t++;
      end
      chk("rst no stale output", t, 0);
      apply_vec(vecs[7], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
